// File: rtl/hunter_ook_encoder.sv
// OOK frame encoder for the fan-remote transmitter.
// Serialises one command word as a pulse-width-coded frame (sync pulse,
// sync low, 3-unit bit cells, trailing gap) and repeats it REPEATS times.
// key is registered so the RF carrier gate never glitches.
module hunter_ook_encoder #(
  parameter int UNIT_CYCLES    = 4000,
  parameter int FRAME_BITS     = 24,
  parameter int SYNC_LOW_UNITS = 12,
  parameter int GAP_UNITS      = 32,
  parameter int REPEATS        = 4
) (
  input  logic                  ref_10mhz,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] cmd_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  abort,
  output logic                  key,
  output logic                  busy,
  output logic                  done
);

  // Unit index range has to cover the sync low span, the gap span and a bit cell.
  localparam int UMAX = (SYNC_LOW_UNITS > GAP_UNITS)
                        ? ((SYNC_LOW_UNITS > 2) ? SYNC_LOW_UNITS : 2)
                        : ((GAP_UNITS > 2) ? GAP_UNITS : 2);
  localparam int TW = $clog2(UNIT_CYCLES);
  localparam int UW = $clog2(UMAX + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int RW = $clog2(REPEATS + 1);

  localparam logic [TW-1:0] T_LOAD      = TW'(UNIT_CYCLES - 1);
  // Sync uses unit 0 for the pulse and units 1..SYNC_LOW_UNITS for the low part.
  localparam logic [UW-1:0] U_SYNC_LAST = UW'(SYNC_LOW_UNITS);
  localparam logic [UW-1:0] U_BIT_LAST  = UW'(2);
  localparam logic [UW-1:0] U_GAP_LAST  = UW'(GAP_UNITS - 1);
  localparam logic [BW-1:0] B_LAST      = BW'(FRAME_BITS - 1);
  localparam logic [RW-1:0] R_LOAD      = RW'(REPEATS);
  localparam logic [RW-1:0] R_ONE       = RW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_BITS, S_GAP} state_t;

  state_t                state, state_n;
  logic [TW-1:0]         timer, timer_n;
  logic [UW-1:0]         unit, unit_n;
  logic [BW-1:0]         bit_idx, bit_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic [FRAME_BITS-1:0] word, word_n;
  logic [RW-1:0]         rep, rep_n;
  logic                  key_n, done_n;
  logic                  boundary;

  assign busy      = (state != S_IDLE);
  assign cmd_ready = !busy && !reset;
  assign boundary  = (timer == '0);

  // State register and all datapath registers; reset clears the envelope at once.
  always_ff @(posedge ref_10mhz) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      unit    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      word    <= '0;
      rep     <= '0;
      key     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      unit    <= unit_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      word    <= word_n;
      rep     <= rep_n;
      key     <= key_n;
      done    <= done_n;
    end
  end

  // Next-state logic; key_n is the envelope level of the unit being entered.
  always_comb begin
    state_n = state;
    timer_n = timer;
    unit_n  = unit;
    bit_n   = bit_idx;
    shreg_n = shreg;
    word_n  = word;
    rep_n   = rep;
    key_n   = key;
    done_n  = 1'b0;

    if (state == S_IDLE) begin
      key_n = 1'b0;
      if (cmd_valid && !abort) begin
        state_n = S_SYNC;
        word_n  = cmd_data;
        shreg_n = cmd_data;
        rep_n   = R_LOAD;
        timer_n = T_LOAD;
        unit_n  = '0;
        bit_n   = '0;
        key_n   = 1'b1;
      end
    end else if (abort) begin
      state_n = S_IDLE;
      key_n   = 1'b0;
    end else if (!boundary) begin
      timer_n = timer - 1'b1;
    end else begin
      timer_n = T_LOAD;
      unit_n  = unit + 1'b1;
      case (state)
        S_SYNC: begin
          if (unit == U_SYNC_LAST) begin
            state_n = S_BITS;
            unit_n  = '0;
            bit_n   = '0;
            key_n   = 1'b1;
          end else begin
            key_n = 1'b0;
          end
        end
        S_BITS: begin
          if (unit == U_BIT_LAST) begin
            shreg_n = shreg << 1;
            unit_n  = '0;
            if (bit_idx == B_LAST) begin
              state_n = S_GAP;
              key_n   = 1'b0;
            end else begin
              bit_n = bit_idx + 1'b1;
              key_n = 1'b1;
            end
          end else if (unit == '0) begin
            // Second unit of the cell stays high only for a 1 bit.
            key_n = shreg[FRAME_BITS-1];
          end else begin
            key_n = 1'b0;
          end
        end
        S_GAP: begin
          key_n = 1'b0;
          if (unit == U_GAP_LAST) begin
            unit_n = '0;
            rep_n  = rep - 1'b1;
            if (rep == R_ONE) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = S_SYNC;
              shreg_n = word;
              bit_n   = '0;
              key_n   = 1'b1;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          key_n   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hunter_ook_encoder.sv
// Bench for hunter_ook_encoder: a queue-based envelope model checked every
// cycle, directed scenarios with literal waveform expectations, then random traffic.
module tb_hunter_ook_encoder;
  localparam int UC = 2, FB = 4, SL = 4, GU = 3, RP = 2;
  localparam int FRAME = (1 + SL + 3*FB + GU) * UC;
  localparam logic [39:0] LIT = 40'b11_00000000_111100_110000_111100_110000_000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic abort = 1'b0;
  logic [FB-1:0] cmd_data = '0;
  logic cmd_ready, key, busy, done;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;
  bit exp_q[$];
  bit m_done = 0;

  hunter_ook_encoder #(
    .UNIT_CYCLES(UC), .FRAME_BITS(FB), .SYNC_LOW_UNITS(SL),
    .GAP_UNITS(GU), .REPEATS(RP)
  ) dut (
    .ref_10mhz(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .abort(abort), .key(key), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void push_units(input bit v, input int n);
    for (int i = 0; i < n*UC; i++) exp_q.push_back(v);
  endfunction

  // Whole transmission as a flat list of per-cycle envelope levels.
  function automatic void push_cmd(input logic [FB-1:0] w);
    for (int r = 0; r < RP; r++) begin
      push_units(1'b1, 1);
      push_units(1'b0, SL);
      for (int b = FB-1; b >= 0; b--) begin
        push_units(1'b1, 1);
        push_units(w[b], 1);
        push_units(1'b0, 1);
      end
      push_units(1'b0, GU);
    end
  endfunction

  // Model: queue front is the key level for the cycle after each edge.
  always @(posedge clk) begin
    m_done = 0;
    if (reset) exp_q.delete();
    else if (exp_q.size() != 0) begin
      if (abort) exp_q.delete();
      else begin
        void'(exp_q.pop_front());
        m_done = (exp_q.size() == 0);
      end
    end else if (cmd_valid && !abort) push_cmd(cmd_data);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("key", key, (exp_q.size() != 0) ? exp_q[0] : 1'b0);
      check("busy", busy, exp_q.size() != 0);
      check("done", done, m_done);
      check("cmd_ready", cmd_ready, (exp_q.size() == 0) && !reset);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit hold);
    logic [39:0] p1, p2, mq;
    int rdy_hi, done_cnt;
    rdy_hi = 0;
    done_cnt = 0;
    cmd_data = 4'b1010;
    cmd_valid = 1'b1;
    tick();
    if (!hold) cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) mq[39-i] = exp_q[i];
    check("model_frame", mq, LIT);
    check("model_len", exp_q.size(), 2*FRAME);
    for (int i = 1; i <= 2*FRAME; i++) begin
      if (i <= FRAME) p1[FRAME-i] = key;
      else p2[2*FRAME-i] = key;
      rdy_hi += int'(cmd_ready);
      done_cnt += int'(done);
      if (i == 5) cmd_data = 4'b0000;
      tick();
    end
    check("frame1", p1, LIT);
    check("frame2", p2, LIT);
    check("done_early", done_cnt, 0);
    check("ready_while_busy", rdy_hi, 0);
    check("done_end", done, 1);
    check("busy_end", busy, 0);
    check("ready_end", cmd_ready, 1);
    if (hold) begin
      tick();
      check("reaccept_key", key, 1);
      check("reaccept_busy", busy, 1);
      cmd_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end else tick();
  endtask

  initial begin
    int done_cnt;
    // Reset held for 3 edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1;
      check("rst_key", key, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", cmd_ready, 0);
    end
    reset = 1'b0;
    tick();
    check("ready_after_rst", cmd_ready, 1);

    run_frame(1'b0);
    run_frame(1'b1);
    repeat (3) tick();

    // Abort in cycle 20.
    cmd_data = 4'b1010;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (19) tick();
    check("busy_before_abort", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_key", key, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", cmd_ready, 1);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      done_cnt += int'(done);
      tick();
    end
    check("abort_no_done", done_cnt, 0);

    // Abort and valid together while idle.
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = 4'b1111;
    tick();
    check("abort_idle_busy", busy, 0);
    tick();
    check("abort_idle_key", key, 0);
    check("abort_idle_busy2", busy, 0);
    abort = 1'b0;
    cmd_valid = 1'b0;
    tick();

    // Reset in cycle 30.
    cmd_data = 4'b0110;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (29) tick();
    reset = 1'b1;
    tick();
    check("midrst_key", key, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    reset = 1'b0;
    tick();
    check("midrst_ready", cmd_ready, 1);
    check("midrst_idle", busy, 0);
    repeat (5) tick();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(3) == 0);
      cmd_data = FB'($urandom);
      abort = ($urandom_range(299) == 0);
      reset = ($urandom_range(999) == 0);
      tick();
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
